// File: rtl/nibble_serial_subtractor16_if.sv
// nibble_serial_subtractor16_if: operand/result bundle for the nibble-serial subtractor
interface nibble_serial_subtractor16_if #(parameter int NIB = 4);
    localparam int W = 4 * NIB;
    logic start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic bin;
    logic busy;
    logic done;
    logic [W-1:0] diff;
    logic bout;
    logic ovf;
    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/nibble_serial_subtractor16.sv
// nibble_serial_subtractor16: a - b - bin computed one 4-bit nibble per clock, LSB nibble first
module nibble_serial_subtractor16 #(parameter int NIB = 4) (
    input logic clk,
    input logic rst_n,
    nibble_serial_subtractor16_if.slave bus
);
    localparam int W = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] k;
    logic [W-1:0] ca, cb, diff;
    logic cbin, brw, bout, ovf;
    logic [4:0] nib;
    logic accept, last;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        accept = (state != RUN) && bus.start;
        last = (k == CW'(NIB - 1));
        nib = {1'b0, ca[{k, 2'b00} +: 4]} - {1'b0, cb[{k, 2'b00} +: 4]} - {4'b0, (k == '0) ? cbin : brw};
        state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    // Counter holds at terminal count; the operand registers keep the captured values for ovf.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k <= '0;
            ca <= '0;
            cb <= '0;
            cbin <= 1'b0;
            brw <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            ca <= bus.a;
            cb <= bus.b;
            cbin <= bus.bin;
            k <= '0;
            diff <= '0;
        end else if (state == RUN) begin
            diff[{k, 2'b00} +: 4] <= nib[3:0];
            brw <= nib[4];
            k <= last ? k : k + CW'(1);
            if (last) begin
                bout <= nib[4];
                ovf <= (ca[W-1] != cb[W-1]) && (nib[3] != ca[W-1]);
            end
        end
    end
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.diff = diff;
    assign bus.bout = bout;
    assign bus.ovf = ovf;
endmodule
